// File: rtl/slide_move_gen.sv
// Sequential ray-walker: counts pseudo-legal moves of one rook/bishop/queen, one square per clock.
// Optional MOVE_LIST_EN build adds move_valid/move_sq outputs streaming each counted target square.
module slide_move_gen #(
    parameter int BOARD_DIM = 8,
    parameter int COORD_W   = 3,
    parameter int CNT_W     = 3,
    parameter int TOT_W     = 6
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           player,
    input  logic [1:0]                     kind,
    input  logic [COORD_W-1:0]             row,
    input  logic [COORD_W-1:0]             col,
    input  logic [BOARD_DIM*BOARD_DIM-1:0] occ,
    input  logic [BOARD_DIM*BOARD_DIM-1:0] white,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [8*CNT_W-1:0]             dir_counts,
    output logic [TOT_W-1:0]               total_count
`ifdef MOVE_LIST_EN
    ,
    output logic                           move_valid,
    output logic [2*COORD_W-1:0]           move_sq
`endif
);

    localparam int NSQ = BOARD_DIM * BOARD_DIM;
    localparam int SW  = COORD_W + 2;
    localparam int IW  = 2 * COORD_W;
    localparam logic signed [SW-1:0] DIM_S = SW'(BOARD_DIM);

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

    state_t                       state, state_nx;
    logic                         player_q;
    logic [7:0]                   mask_q;
    logic [COORD_W-1:0]           row_q, col_q;
    logic [NSQ-1:0]               occ_q, white_q;
    logic [2:0]                   dir_q;
    logic [COORD_W:0]             step_q;
    logic [7:0][CNT_W-1:0]        cnt_q;
    logic [TOT_W-1:0]             total_q;
    logic                         err_q;

    // bit 3 = found, bits 2:0 = lowest enabled direction at or above 'from'
    function automatic logic [3:0] next_dir(input logic [7:0] m, input int from);
        logic [3:0] r;
        r = 4'b0;
        for (int i = 7; i >= 0; i--)
            if (m[i] && i >= from) r = {1'b1, 3'(i)};
        return r;
    endfunction

    function automatic logic [7:0] kind_mask(input logic [1:0] k);
        case (k)
            2'b00:   return 8'h0F;
            2'b01:   return 8'hF0;
            2'b10:   return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    logic coord_bad;
    generate
        if (BOARD_DIM >= (1 << COORD_W)) begin : g_full
            assign coord_bad = 1'b0;
        end else begin : g_part
            assign coord_bad = (row >= COORD_W'(BOARD_DIM)) || (col >= COORD_W'(BOARD_DIM));
        end
    endgenerate

    logic       accept, bad_req;
    logic [3:0] first_dir, nd;
    assign accept    = (state == S_IDLE) && start;
    assign bad_req   = (kind == 2'b11) || coord_bad;
    assign first_dir = next_dir(kind_mask(kind), 0);
    assign nd        = next_dir(mask_q, int'(dir_q) + 1);

    // Candidate square; two spare bits keep both under- and overflow visibly off-board.
    logic signed [SW-1:0] row_s, col_s, step_s, rr, cc;
    logic                 up, dn, lf, rt, off, sq_occ, own, take, end_dir;
    logic [IW-1:0]        idx;

    assign row_s  = {2'b00, row_q};
    assign col_s  = {2'b00, col_q};
    assign step_s = {1'b0, step_q};

    always_comb begin
        up = (dir_q == 3'd2) || (dir_q == 3'd4) || (dir_q == 3'd5);
        dn = (dir_q == 3'd3) || (dir_q == 3'd6) || (dir_q == 3'd7);
        lf = (dir_q == 3'd0) || (dir_q == 3'd4) || (dir_q == 3'd6);
        rt = (dir_q == 3'd1) || (dir_q == 3'd5) || (dir_q == 3'd7);
        rr = up ? row_s + step_s : (dn ? row_s - step_s : row_s);
        cc = rt ? col_s + step_s : (lf ? col_s - step_s : col_s);
        off = rr[SW-1] || (rr >= DIM_S) || cc[SW-1] || (cc >= DIM_S);
        idx = IW'(rr[COORD_W-1:0]) * IW'(BOARD_DIM) + IW'(cc[COORD_W-1:0]);
        sq_occ  = !off && occ_q[idx];
        own     = sq_occ && (white_q[idx] == player_q);
        take    = (state == S_WALK) && !off && !own;
        end_dir = off || sq_occ;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = bad_req ? S_DONE : S_WALK;
            S_WALK: begin
                busy = 1'b1;
                if (end_dir && !nd[3]) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            player_q <= 1'b0;
            mask_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            occ_q    <= '0;
            white_q  <= '0;
            dir_q    <= '0;
            step_q   <= '0;
            cnt_q    <= '0;
            total_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            player_q <= player;
            mask_q   <= kind_mask(kind);
            row_q    <= row;
            col_q    <= col;
            occ_q    <= occ;
            white_q  <= white;
            dir_q    <= first_dir[2:0];
            step_q   <= (COORD_W+1)'(1);
            cnt_q    <= '0;
            total_q  <= '0;
            err_q    <= bad_req;
        end else if (state == S_WALK) begin
            if (take) begin
                cnt_q[dir_q] <= cnt_q[dir_q] + CNT_W'(1);
                total_q      <= total_q + TOT_W'(1);
            end
            if (end_dir) begin
                if (nd[3]) dir_q <= nd[2:0];
                step_q <= (COORD_W+1)'(1);
            end else begin
                step_q <= step_q + (COORD_W+1)'(1);
            end
        end
    end

    assign err         = err_q;
    assign dir_counts  = cnt_q;
    assign total_count = total_q;

`ifdef MOVE_LIST_EN
    assign move_valid = take;
    assign move_sq    = {rr[COORD_W-1:0], cc[COORD_W-1:0]};
`endif

endmodule

// File: tb/tb_slide_move_gen.sv
// Directed, table-driven bench for slide_move_gen (default 8x8 board), with hand sequences
// for reset mid-walk, start while busy, and start coinciding with done.
module tb_slide_move_gen;

    localparam int CW = 3, NW = 3, TW = 6, NSQ = 64;

    logic            clock = 1'b0;
    logic            reset, start, player;
    logic [1:0]      kind;
    logic [CW-1:0]   row, col;
    logic [NSQ-1:0]  occ, white;
    logic            busy, done, err;
    logic [8*NW-1:0] dir_counts;
    logic [TW-1:0]   total_count;
`ifdef MOVE_LIST_EN
    logic            move_valid;
    logic [2*CW-1:0] move_sq;
`endif

    slide_move_gen dut (
        .clock(clock), .reset(reset), .start(start), .player(player), .kind(kind),
        .row(row), .col(col), .occ(occ), .white(white), .busy(busy), .done(done),
        .err(err), .dir_counts(dir_counts), .total_count(total_count)
`ifdef MOVE_LIST_EN
        , .move_valid(move_valid), .move_sq(move_sq)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        pl;
        logic [1:0]  kd;
        logic [2:0]  r, c;
        logic [63:0] oc, wh;
        logic [23:0] cnt;
        logic [5:0]  tot;
        logic        er;
        int          lat;
    } vec_t;

    vec_t vecs[7];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [23:0] pk(int l, int r, int u, int d, int ul, int ur, int dl, int dr);
        return {3'(dr), 3'(dl), 3'(ur), 3'(ul), 3'(d), 3'(u), 3'(r), 3'(l)};
    endfunction

    function automatic logic [63:0] sq(int rr, int cc);
        logic [63:0] v;
        v = '0;
        v[rr*8+cc] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done; latency counts the accepting edge as 1.
    task automatic run(input vec_t v, input bit disturb, output int lat, output int moves);
        player = v.pl; kind = v.kd; row = v.r; col = v.c; occ = v.oc; white = v.wh;
        start = 1'b1;
        lat = 0;
        moves = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            lat++;
            if (lat == 1) start = 1'b0;
            if (disturb && lat == 3) begin
                start = 1'b1; kind = 2'b01; occ = '0; white = '1;
            end
            if (disturb && lat == 4) start = 1'b0;
`ifdef MOVE_LIST_EN
            if (move_valid) moves++;
`endif
            if (done) break;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen after %0d cycles", lat);
        end
    endtask

    task automatic check_vec(input vec_t v, input int lat, input string tag);
        chk({tag, ".counts"}, 64'(dir_counts), 64'(v.cnt));
        chk({tag, ".total"}, 64'(total_count), 64'(v.tot));
        chk({tag, ".err"}, 64'(err), 64'(v.er));
        chk({tag, ".latency"}, 64'(lat), 64'(v.lat));
        chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, mv, seen;

        vecs[0] = '{1'b1, 2'b00, 3'd0, 3'd0, '0, '0, pk(0,7,7,0,0,0,0,0), 6'd14, 1'b0, 19};
        vecs[1] = '{1'b1, 2'b10, 3'd3, 3'd3, sq(3,5) | sq(5,5), sq(3,5),
                    pk(3,1,4,3,3,2,3,3), 6'd22, 1'b0, 30};
        vecs[2] = '{1'b0, 2'b01, 3'd0, 3'd0, sq(1,1), sq(1,1), pk(0,0,0,0,0,1,0,0), 6'd1, 1'b0, 5};
        vecs[3] = '{1'b1, 2'b11, 3'd2, 3'd2, '0, '0, pk(0,0,0,0,0,0,0,0), 6'd0, 1'b1, 1};
        vecs[4] = '{1'b0, 2'b00, 3'd7, 3'd7, sq(7,3) | sq(2,7), sq(2,7),
                    pk(3,0,0,5,0,0,0,0), 6'd8, 1'b0, 12};
        vecs[5] = '{1'b1, 2'b10, 3'd0, 3'd7, '0, '0, pk(7,0,7,0,7,0,0,0), 6'd21, 1'b0, 30};
        vecs[6] = '{1'b1, 2'b01, 3'd4, 3'd2, sq(5,3) | sq(2,0), sq(5,3),
                    pk(0,0,0,0,2,0,2,4), 6'd8, 1'b0, 12};

        reset = 1'b0; start = 1'b0; player = 1'b0; kind = 2'b00;
        row = '0; col = '0; occ = '0; white = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.err", 64'(err), 64'd0);
        chk("reset.counts", 64'(dir_counts), 64'd0);
        chk("reset.total", 64'(total_count), 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 7; i++) begin
            run(vecs[i], 1'b0, lat, mv);
            check_vec(vecs[i], lat, $sformatf("vec%0d", i));
            @(posedge clock); #1;
            chk($sformatf("vec%0d.hold_counts", i), 64'(dir_counts), 64'(vecs[i].cnt));
            chk($sformatf("vec%0d.done_cleared", i), 64'(done), 64'd0);
        end

        // Reset in the middle of the rook walk.
        player = 1'b1; kind = 2'b00; row = '0; col = '0; occ = '0; white = '0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("midreset.busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("midreset.busy", 64'(busy), 64'd0);
        chk("midreset.counts", 64'(dir_counts), 64'd0);
        chk("midreset.total", 64'(total_count), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        chk("midreset.no_done", 64'(seen), 64'd0);
        run(vecs[0], 1'b0, lat, mv);
        check_vec(vecs[0], lat, "midreset.rerun");
        @(posedge clock); #1;

        // start while busy plus mid-walk board change must not disturb the queen walk.
        run(vecs[1], 1'b1, lat, mv);
        check_vec(vecs[1], lat, "disturb");
`ifdef MOVE_LIST_EN
        chk("disturb.move_pulses", 64'(mv), 64'd22);
`endif

        // start presented in the DONE cycle is ignored.
        kind = 2'b11; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("start_at_done.err", 64'(err), 64'd0);
        chk("start_at_done.busy", 64'(busy), 64'd0);
        chk("start_at_done.counts", 64'(dir_counts), 64'(vecs[1].cnt));
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        chk("start_at_done.no_done", 64'(seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
